// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the instruction-fetch buffer.
//   fetch_state_t  : fetch handshake states (IDLE / WAIT / DROP)
//   DEFAULT_DEPTH  : default instruction queue depth
//   DEFAULT_XLEN   : default address / instruction width
package if_fetch_buffer_pkg;

   localparam int DEFAULT_DEPTH = 2;
   localparam int DEFAULT_XLEN  = 32;

   // IDLE: nothing outstanding
   // WAIT: request issued, result will be kept
   // DROP: request issued, result will be discarded
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_buffer_fetch_fifo.sv
// fetch_fifo: small synchronous queue of {pc, instruction} pairs.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   clear              empties the queue; wins over push and pop
//   push, push_pc,
//   push_inst          enqueue one entry
//   pop                dequeue the head (ignored when empty)
//   count              number of valid entries (0..DEPTH)
//   head_pc, head_inst head entry contents
module fetch_fifo
   import if_fetch_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int XLEN  = DEFAULT_XLEN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [XLEN-1:0]          push_pc,
   input  logic [XLEN-1:0]          push_inst,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic [XLEN-1:0]          head_pc,
   output logic [XLEN-1:0]          head_inst
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [XLEN-1:0] inst_mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic            do_push;
   logic            do_pop;

   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; entries are only visible through count.
   always_ff @(posedge clk) begin
      if (rst && !clear && do_push) begin
         pc_mem[wr_ptr]   <= push_pc;
         inst_mem[wr_ptr] <= push_inst;
      end
   end

   assign head_pc   = pc_mem[rd_ptr];
   assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: IF-stage fetch engine with an instruction queue toward ID.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   pc_in                        current fetch address from the PC register
//   fetch_stall                  1 = PC register holds this cycle
//   flush                        redirect from EX (PC loads jump target)
//   imem_req, imem_addr          instruction memory request / address
//   imem_ack, imem_rdata         same-cycle acknowledge and instruction word
//   id_valid, id_ready           handshake toward ID
//   id_pc, id_inst               queue head address / instruction
module if_fetch_buffer
   import if_fetch_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int XLEN  = DEFAULT_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_in,
   output logic            fetch_stall,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_inst
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] addr_next;
   logic            run_q;
   logic            active;
   logic            push;
   logic [CW-1:0]   count;

   // run_q keeps the engine quiet for one extra cycle after reset release.
   assign active = rst && run_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         addr_q <= '0;
         run_q  <= 1'b0;
      end else begin
         state  <= state_next;
         addr_q <= addr_next;
         run_q  <= 1'b1;
      end
   end

   // In IDLE the address comes straight from the PC so a zero-wait memory
   // sustains one fetch per cycle; once a request is pending the address is
   // frozen in addr_q until the memory acknowledges it.
   always_comb begin
      state_next = state;
      addr_next  = addr_q;
      imem_req   = 1'b0;
      imem_addr  = pc_in;
      push       = 1'b0;
      if (active) begin
         case (state)
            IDLE: begin
               imem_req  = (count != FULL);
               imem_addr = pc_in;
               if (imem_req) begin
                  if (imem_ack) begin
                     push = !flush;
                  end else begin
                     addr_next  = pc_in;
                     state_next = flush ? DROP : WAIT;
                  end
               end
            end
            WAIT: begin
               imem_req  = 1'b1;
               imem_addr = addr_q;
               if (imem_ack) begin
                  push       = !flush;
                  state_next = IDLE;
               end else if (flush) begin
                  state_next = DROP;
               end
            end
            DROP: begin
               imem_req  = 1'b1;
               imem_addr = addr_q;
               if (imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // The PC may only advance on a useful handshake; a redirect always loads.
   assign fetch_stall = !active ||
                        (!(imem_req && imem_ack && (state != DROP)) && !flush);

   assign id_valid = rst && (count != '0);

   fetch_fifo #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (push),
      .push_pc   (imem_addr),
      .push_inst (imem_rdata),
      .pop       (id_valid && id_ready),
      .count     (count),
      .head_pc   (id_pc),
      .head_inst (id_inst)
   );

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer: a transaction-level reference
// (PC register, outstanding-request record, expected instruction queue)
// predicts every output each cycle; directed scenarios are followed by a
// randomized run.
module tb_if_fetch_buffer;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   logic        clk;
   logic        rst;
   logic [31:0] pc_in;
   logic        fetch_stall;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   int errors;
   int checks;

   // reference state
   entry_t      mq[$];
   logic [31:0] m_pc;
   bit          m_run_flag;
   bit          m_out;
   bit          m_discard;
   logic [31:0] m_out_addr;
   int          m_wait;
   int          m_lat;

   if_fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_in       (pc_in),
      .fetch_stall (fetch_stall),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_inst     (id_inst)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   // One clock cycle: drive inputs, predict outputs, compare, advance model.
   // lat < 0 picks a random memory latency for a request that starts now.
   task automatic applyStimulus(input bit r, input bit f, input logic [31:0] tgt,
                                input bit rdy, input int lat);
      bit          run;
      bit          e_req;
      bit          e_stall;
      bit          e_valid;
      bit          ack;
      logic [31:0] e_addr;
      entry_t      head;

      run     = r && m_run_flag;
      e_req   = run && (m_out || (mq.size() < DEPTH));
      e_addr  = m_out ? m_out_addr : m_pc;
      if (e_req && !m_out) begin
         m_lat  = (lat < 0) ? int'($urandom_range(3, 0)) : lat;
         m_wait = 0;
      end
      ack     = e_req && (m_wait == m_lat);
      e_stall = !run || (!(ack && !m_discard) && !f);
      e_valid = r && (mq.size() != 0);

      rst        = r;
      flush      = f;
      id_ready   = rdy;
      pc_in      = m_pc;
      imem_ack   = ack;
      imem_rdata = $urandom;

      #3;
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      checkOutput("fetch_stall", {31'b0, fetch_stall}, {31'b0, e_stall});
      checkOutput("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
      if (e_req) checkOutput("imem_addr", imem_addr, e_addr);
      if (e_valid) begin
         head = mq[0];
         checkOutput("id_pc", id_pc, head.pc);
         checkOutput("id_inst", id_inst, head.inst);
      end

      if (!r) begin
         mq.delete();
         m_out      = 0;
         m_discard  = 0;
         m_run_flag = 0;
         m_pc       = 32'h0;
      end else begin
         m_run_flag = 1;
         if (f) begin
            mq.delete();
         end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (ack && !m_discard) mq.push_back('{e_addr, imem_rdata});
         end
         if (ack) begin
            m_out     = 0;
            m_discard = 0;
         end else if (e_req) begin
            m_out      = 1;
            m_out_addr = e_addr;
            m_discard  = m_discard || f;
            m_wait++;
         end
         if (f) m_pc = tgt;
         else if (!e_stall) m_pc = m_pc + 32'd4;
      end

      @(posedge clk);
      #1;
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      clk        = 0;
      rst        = 0;
      flush      = 0;
      id_ready   = 0;
      pc_in      = 0;
      imem_ack   = 0;
      imem_rdata = 0;
      m_pc       = 0;
      m_run_flag = 0;
      m_out      = 0;
      m_discard  = 0;
      m_out_addr = 0;
      m_wait     = 0;
      m_lat      = 0;
      @(posedge clk);
      #1;

      // reset, quiet cycle after release, then zero-wait stream 0,4,8
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 0);

      // slow memory at 0x10: three wait cycles
      applyStimulus(1, 1, 32'h10, 1, 0);
      for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 1, 3);

      // ID stalled: queue fills, request stops, resumes after one pop
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0);

      // flush with full queue and simultaneous pop
      applyStimulus(1, 1, 32'h20, 1, 0);
      // request 0x20 waits, flush to 0x40 while waiting -> result dropped
      applyStimulus(1, 0, 0, 1, 3);
      applyStimulus(1, 1, 32'h40, 1, 3);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 0);

      // reset while a request is outstanding
      applyStimulus(1, 0, 0, 1, 3);
      applyStimulus(0, 0, 0, 1, 3);
      applyStimulus(1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(99, 0) != 0,
                       $urandom_range(9, 0) == 0,
                       $urandom & 32'hFFFF_FFFC,
                       $urandom_range(1, 0) == 1,
                       -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_buffer.md
IF_FETCH_BUFFER -- requirements
Module: if_fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 2, instruction queue entries (power of two, >= 2).
REQ-002 Parameter XLEN, default 32, address/instruction width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 pc_in  input  XLEN  current fetch address from the PC register.
REQ-006 fetch_stall  output  1  1 = PC register holds its value this cycle.
REQ-007 flush  input  1  redirect from EX; PC register loads the jump target this cycle.
REQ-008 imem_req  output  1  instruction-memory request, held until acknowledged.
REQ-009 imem_addr  output  XLEN  request address.
REQ-010 imem_ack  input  1  request accepted; imem_rdata valid in the same cycle.
REQ-011 imem_rdata  input  XLEN  instruction word.
REQ-012 id_valid  output  1  queue head valid toward ID.
REQ-013 id_ready  input  1  ID accepts head (the inverse of the ID stall).
REQ-014 id_pc / id_inst  output  XLEN each  queue head address / instruction.

Function
REQ-015 FSM states: IDLE (no request outstanding), WAIT (request issued, not acked), DROP (request outstanding, result discarded).
REQ-016 IDLE: imem_req = (count < DEPTH); imem_addr = pc_in combinationally.
REQ-017 IDLE, imem_req=1, imem_ack=0 -> latch pc_in into addr_q; next WAIT.
REQ-018 WAIT/DROP: imem_req = 1; imem_addr = addr_q, stable until ack.
REQ-019 WAIT + imem_ack -> next IDLE; DROP + imem_ack -> next IDLE, data discarded.
REQ-020 Push {imem_addr, imem_rdata} into queue on handshake (imem_req && imem_ack) in IDLE or WAIT when flush=0.
REQ-021 fetch_stall = !(imem_req && imem_ack && state != DROP) && !flush; flush always forces fetch_stall=0.
REQ-022 Zero-wait memory (ack in the issuing cycle): one instruction per cycle, no WAIT entry.
REQ-023 id_valid = (count != 0); id_pc/id_inst = head entry; pop on id_valid && id_ready.
REQ-024 Push and pop in the same cycle -> count unchanged, FIFO order preserved.
REQ-025 Full (count == DEPTH): no new request; resumes the cycle after a pop.
REQ-026 Empty: id_valid=0; id_ready ignored.
REQ-027 Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
REQ-028 flush: queue emptied next cycle (count=0, pointers 0); takes priority over push and pop.
REQ-029 flush in WAIT without ack -> DROP; flush in WAIT with ack -> IDLE, no push.
REQ-030 flush in IDLE with handshake -> no push; without ack, with imem_req=1 -> DROP with addr_q = pc_in.
REQ-031 flush in DROP -> remain DROP (or IDLE if acked); no effect on outstanding request.
REQ-032 At most one memory request outstanding at any time.

Reset
REQ-033 While rst=0 at posedge: state=IDLE, count=0, pointers=0, addr_q=0.
REQ-034 During and one cycle after reset: imem_req=0, id_valid=0, fetch_stall=1.
REQ-035 Reset asserted mid-request abandons it; the memory model also resets.

Structure
REQ-036 Shared package holds the state encoding (IDLE/WAIT/DROP), the default DEPTH and XLEN.
REQ-037 Queue is one sub-module, fetch_fifo (sync push/pop/clear, count output); FSM and handshake stay in if_fetch_buffer.

Verification
REQ-038 Zero-wait memory, id_ready=1, pc 0,4,8 -> id_pc 0,4,8 on consecutive cycles, fetch_stall=0 each cycle.
REQ-039 ack delayed 3 cycles at pc=0x10 -> imem_addr=0x10 held 4 cycles, fetch_stall=1 for 3 cycles, push on cycle 4.
REQ-040 id_ready=0, DEPTH=2 -> after 2 pushes imem_req=0 and fetch_stall=1; one pop -> request to next pc resumes.
REQ-041 flush while WAIT on 0x20, ack 2 cycles later -> DROP, 0x20 data never on id_*, next request to flush target.
REQ-042 flush with queue holding 2 entries and simultaneous pop -> id_valid=0 next cycle, count=0.
REQ-043 rst=0 during WAIT -> next cycle IDLE, imem_req=0, id_valid=0; after release, fetch restarts at pc_in.
